// File: rtl/conv_seq_ctrl.sv
// ---------------------------------------------------------------------------
// conv_seq_ctrl
// Sequencer for the convolution datapath: z[i] = sum_k x[k]*y[i-k] for
// i = 0..N+M-2. For every output index it clears the external MAC, streams
// the valid (x[k], y[i-k]) address pairs to the sample memories, lets the
// last product settle into the MAC and then strobes a write into Z.
//
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   start_i           single-cycle start request (sampled in IDLE only)
//   size_x_i/size_y_i N and M, legal range 1..2**AW_X / 1..2**AW_Y
//   addr_x_o/addr_y_o X/Y read addresses, valid while rd_en_o=1
//   rd_en_o           X/Y memory read enable
//   mac_clr_o         clear MAC accumulator
//   mac_en_o          accumulate (memory data valid this cycle)
//   addr_z_o/z_we_o   Z result write address / write enable
//   busy_o            sequence in progress
//   done_o            one-cycle completion pulse
//   err_o             one-cycle pulse: start rejected (illegal size) or run aborted
//   abort_i           only with CONV_SEQ_ABORT_EN defined: cancel the running sequence
//
// Optional feature macro: CONV_SEQ_ABORT_EN (adds abort_i).
// ---------------------------------------------------------------------------
module conv_seq_ctrl #(
    parameter int AW_X = 5,
    parameter int AW_Y = 5,
    localparam int AW_Z = ((AW_X > AW_Y) ? AW_X : AW_Y) + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [AW_X:0]   size_x_i,
    input  logic [AW_Y:0]   size_y_i,
`ifdef CONV_SEQ_ABORT_EN
    input  logic            abort_i,
`endif
    output logic [AW_X-1:0] addr_x_o,
    output logic [AW_Y-1:0] addr_y_o,
    output logic            rd_en_o,
    output logic            mac_clr_o,
    output logic            mac_en_o,
    output logic [AW_Z-1:0] addr_z_o,
    output logic            z_we_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o
);

    // One extra bit over AW_Z so that i+1-M and friends never wrap.
    localparam int IW = AW_Z + 1;
    localparam logic [AW_X:0] N_MAX = {1'b1, {AW_X{1'b0}}};
    localparam logic [AW_Y:0] M_MAX = {1'b1, {AW_Y{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_FETCH = 3'd2,
        S_DRAIN = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    state_e          state_q;
    logic [AW_X:0]   n_q;
    logic [AW_Y:0]   m_q;
    logic [IW-1:0]   i_q;
    logic [IW-1:0]   k_q;
    logic [IW-1:0]   kend_q;

    logic [IW-1:0]   n_ext_s;
    logic [IW-1:0]   m_ext_s;
    logic [IW-1:0]   kmin_d;
    logic [IW-1:0]   kend_d;
    logic [IW-1:0]   k_inc_s;
    logic [AW_Y-1:0] ay_init_s;
    logic [AW_Y-1:0] ay_inc_s;
    logic            last_i_s;
    logic            size_ok_s;
    logic            abort_s;
    logic            abort_hit_s;

    // Index bounds for the current output sample and the next address pair.
    always_comb begin
        n_ext_s = IW'(n_q);
        m_ext_s = IW'(m_q);
        // kmin = max(0, i-M+1), evaluated without going negative
        if ((i_q + IW'(1)) >= m_ext_s) begin
            kmin_d = i_q + IW'(1) - m_ext_s;
        end else begin
            kmin_d = '0;
        end
        // kend = min(i, N-1)
        if (i_q < (n_ext_s - IW'(1))) begin
            kend_d = i_q;
        end else begin
            kend_d = n_ext_s - IW'(1);
        end
        k_inc_s   = k_q + IW'(1);
        ay_init_s = AW_Y'(i_q - kmin_d);
        ay_inc_s  = AW_Y'(i_q - k_inc_s);
        last_i_s  = (i_q == (n_ext_s + m_ext_s - IW'(2)));
        size_ok_s = (size_x_i != '0) && (size_x_i <= N_MAX) &&
                    (size_y_i != '0) && (size_y_i <= M_MAX);
    end

    // Abort qualification: only a running sequence (INIT..WRITE) can be cancelled.
    always_comb begin
`ifdef CONV_SEQ_ABORT_EN
        abort_s = abort_i;
`else
        abort_s = 1'b0;
`endif
        abort_hit_s = abort_s && (state_q != S_IDLE) && (state_q != S_DONE);
    end

    // Sequencer FSM; every output is registered alongside the state it belongs to.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            n_q       <= '0;
            m_q       <= '0;
            i_q       <= '0;
            k_q       <= '0;
            kend_q    <= '0;
            addr_x_o  <= '0;
            addr_y_o  <= '0;
            addr_z_o  <= '0;
            rd_en_o   <= 1'b0;
            mac_clr_o <= 1'b0;
            mac_en_o  <= 1'b0;
            z_we_o    <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            // Strobes are single-cycle unless a state re-asserts them.
            rd_en_o   <= 1'b0;
            mac_clr_o <= 1'b0;
            mac_en_o  <= 1'b0;
            z_we_o    <= 1'b0;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
            if (abort_hit_s) begin
                state_q <= S_IDLE;
                busy_o  <= 1'b0;
                err_o   <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        busy_o <= 1'b0;
                        if (start_i) begin
                            if (size_ok_s) begin
                                n_q       <= size_x_i;
                                m_q       <= size_y_i;
                                i_q       <= '0;
                                busy_o    <= 1'b1;
                                mac_clr_o <= 1'b1;
                                state_q   <= S_INIT;
                            end else begin
                                err_o <= 1'b1;
                            end
                        end
                    end
                    S_INIT: begin
                        k_q      <= kmin_d;
                        kend_q   <= kend_d;
                        addr_x_o <= AW_X'(kmin_d);
                        addr_y_o <= ay_init_s;
                        rd_en_o  <= 1'b1;
                        state_q  <= S_FETCH;
                    end
                    S_FETCH: begin
                        // Data read this cycle is valid next cycle: mac_en trails rd_en.
                        mac_en_o <= 1'b1;
                        if (k_q == kend_q) begin
                            state_q <= S_DRAIN;
                        end else begin
                            k_q      <= k_inc_s;
                            addr_x_o <= AW_X'(k_inc_s);
                            addr_y_o <= ay_inc_s;
                            rd_en_o  <= 1'b1;
                        end
                    end
                    S_DRAIN: begin
                        z_we_o   <= 1'b1;
                        addr_z_o <= AW_Z'(i_q);
                        state_q  <= S_WRITE;
                    end
                    S_WRITE: begin
                        if (last_i_s) begin
                            busy_o  <= 1'b0;
                            done_o  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            i_q       <= i_q + IW'(1);
                            mac_clr_o <= 1'b1;
                            state_q   <= S_INIT;
                        end
                    end
                    S_DONE: begin
                        busy_o  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: begin
                        busy_o  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_conv_seq_ctrl
// Self-checking bench for conv_seq_ctrl (AW_X = AW_Y = 5). A behavioural model
// expands every accepted start into the expected per-cycle output trace from
// the convolution index rules; a compare process checks the DUT against it on
// every falling edge. Directed scenarios add hand-computed literal checks.
// ---------------------------------------------------------------------------
module tb_conv_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       start_i = 1'b0;
    logic       abort_i = 1'b0;
    logic [5:0] size_x_i = 6'd0;
    logic [5:0] size_y_i = 6'd0;
    logic [4:0] addr_x_o;
    logic [4:0] addr_y_o;
    logic [5:0] addr_z_o;
    logic       rd_en_o, mac_clr_o, mac_en_o, z_we_o, busy_o, done_o, err_o;

    always #5 clk = ~clk;

    conv_seq_ctrl #(.AW_X(5), .AW_Y(5)) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .size_x_i  (size_x_i),
        .size_y_i  (size_y_i),
`ifdef CONV_SEQ_ABORT_EN
        .abort_i   (abort_i),
`endif
        .addr_x_o  (addr_x_o),
        .addr_y_o  (addr_y_o),
        .rd_en_o   (rd_en_o),
        .mac_clr_o (mac_clr_o),
        .mac_en_o  (mac_en_o),
        .addr_z_o  (addr_z_o),
        .z_we_o    (z_we_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .err_o     (err_o)
    );

    typedef struct packed {
        logic       rd;
        logic       clr;
        logic       en;
        logic       we;
        logic       busy;
        logic       done;
        logic       err;
        logic [4:0] ax;
        logic [4:0] ay;
        logic [5:0] az;
    } exp_t;

    exp_t q[$];
    exp_t cur = '0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, got, exp);
        end
    endtask

    // Expected trace of one full run: per output i, a clear cycle, one cycle per
    // valid k, one cycle for the last product, one write cycle; then done.
    function automatic void push_run(input int n, input int m);
        exp_t r;
        int kmin, kend;
        for (int i = 0; i <= n + m - 2; i++) begin
            kmin = (i - m + 1 > 0) ? (i - m + 1) : 0;
            kend = (i < n - 1) ? i : (n - 1);
            r = '0; r.busy = 1'b1; r.clr = 1'b1;
            q.push_back(r);
            for (int k = kmin; k <= kend; k++) begin
                r = '0; r.busy = 1'b1; r.rd = 1'b1;
                r.ax = 5'(k); r.ay = 5'(i - k); r.en = (k > kmin);
                q.push_back(r);
            end
            r = '0; r.busy = 1'b1; r.en = 1'b1;
            q.push_back(r);
            r = '0; r.busy = 1'b1; r.we = 1'b1; r.az = 6'(i);
            q.push_back(r);
        end
        r = '0; r.done = 1'b1;
        q.push_back(r);
    endfunction

    // Model: reacts to the inputs at the same edge the DUT samples them.
    always @(posedge clk) begin
        exp_t r;
        int n, m;
        n = int'(size_x_i);
        m = int'(size_y_i);
        if (rst_i) begin
            q.delete();
        end else if (abort_i && cur.busy) begin
            q.delete();
            r = '0; r.err = 1'b1;
            q.push_back(r);
        end else if (start_i && q.size() == 0 && !cur.done) begin
            if (n >= 1 && n <= 32 && m >= 1 && m <= 32) begin
                push_run(n, m);
            end else begin
                r = '0; r.err = 1'b1;
                q.push_back(r);
            end
        end
    end

    // Compare: every cycle, outputs against the model's expected record.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) e = q.pop_front();
        else e = '0;
        cur = e;
        chk("strobes{rd,clr,en,we,busy,done,err}",
            int'({rd_en_o, mac_clr_o, mac_en_o, z_we_o, busy_o, done_o, err_o}),
            int'({e.rd, e.clr, e.en, e.we, e.busy, e.done, e.err}));
        if (e.rd) begin
            chk("addr_x", int'(addr_x_o), int'(e.ax));
            chk("addr_y", int'(addr_y_o), int'(e.ay));
        end
        if (e.we) begin
            chk("addr_z", int'(addr_z_o), int'(e.az));
        end
    end

    int px[$];
    int py[$];
    int zq[$];
    int nclr, nen;
    int px_exp [6] = '{0, 0, 1, 1, 2, 2};
    int py_exp [6] = '{0, 1, 0, 1, 0, 1};

    // One run from start; cycle c counts falling edges after the start-sampling edge.
    task automatic run_scn(input int n, input int m, input int exp_done,
                           input int exp_writes, input bit restart);
        int c, dc, nb;
        bit got_done;
        px.delete(); py.delete(); zq.delete();
        nclr = 0; nen = 0; nb = 0; dc = 0; c = 0; got_done = 1'b0;
        @(negedge clk);
        start_i = 1'b1; size_x_i = 6'(n); size_y_i = 6'(m);
        while (c < 200 && !got_done) begin
            @(negedge clk);
            c++;
            if (busy_o) nb++;
            if (mac_clr_o) nclr++;
            if (mac_en_o) nen++;
            if (rd_en_o) begin px.push_back(int'(addr_x_o)); py.push_back(int'(addr_y_o)); end
            if (z_we_o) zq.push_back(int'(addr_z_o));
            if (done_o) begin got_done = 1'b1; dc = c; end
            start_i = (restart && c == 5);
            if (start_i) begin size_x_i = 6'd1; size_y_i = 6'd1; end
        end
        start_i = 1'b0;
        chk("done_seen", int'(got_done), 1);
        chk("done_cycle", dc, exp_done);
        chk("busy_cycles", nb, exp_done - 1);
        chk("n_writes", zq.size(), exp_writes);
        foreach (zq[w]) chk("addr_z_seq", zq[w], w);
    endtask

    task automatic check_pairs_3x2();
        chk("n_pairs", px.size(), 6);
        chk("n_mac_clr", nclr, 4);
        chk("n_mac_en", nen, 6);
        for (int p = 0; p < 6 && p < px.size(); p++) begin
            chk("pair_x", px[p], px_exp[p]);
            chk("pair_y", py[p], py_exp[p]);
        end
    endtask

    task automatic err_scn(input int n, input int m);
        @(negedge clk);
        start_i = 1'b1; size_x_i = 6'(n); size_y_i = 6'(m);
        @(negedge clk);
        start_i = 1'b0;
        chk("err_pulse", int'(err_o), 1);
        chk("err_busy", int'(busy_o), 0);
        chk("err_done", int'(done_o), 0);
        @(negedge clk);
        chk("err_len", int'(err_o), 0);
        chk("err_zwe", int'(z_we_o), 0);
        chk("err_busy2", int'(busy_o), 0);
    endtask

    task automatic rst_scn();
        int c, nd, nw;
        bit found;
        c = 0; found = 1'b0; nd = 0; nw = 0;
        @(negedge clk);
        start_i = 1'b1; size_x_i = 6'd4; size_y_i = 6'd4;
        while (c < 100 && !found) begin
            @(negedge clk);
            start_i = 1'b0;
            c++;
            if (rd_en_o && (int'(addr_x_o) + int'(addr_y_o) == 2)) found = 1'b1;
        end
        chk("rst_fetch_i2_seen", int'(found), 1);
        rst_i = 1'b1;
        @(negedge clk);
        chk("rst_outputs_zero",
            int'({addr_x_o, addr_y_o, addr_z_o, rd_en_o, mac_clr_o, mac_en_o,
                  z_we_o, busy_o, done_o, err_o}), 0);
        rst_i = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (done_o) nd++;
            if (z_we_o) nw++;
        end
        chk("rst_no_done", nd, 0);
        chk("rst_no_zwe", nw, 0);
    endtask

`ifdef CONV_SEQ_ABORT_EN
    task automatic abort_scn();
        int c, nw, ne;
        bit found;
        c = 0; found = 1'b0; nw = 0; ne = 0; nclr = 0;
        @(negedge clk);
        start_i = 1'b1; size_x_i = 6'd3; size_y_i = 6'd3;
        while (c < 100 && !found) begin
            @(negedge clk);
            start_i = 1'b0;
            c++;
            if (mac_clr_o) nclr++;
            if (nclr == 2 && mac_en_o && !rd_en_o) found = 1'b1;
        end
        chk("abort_drain_i1_seen", int'(found), 1);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        chk("abort_err", int'(err_o), 1);
        chk("abort_busy", int'(busy_o), 0);
        chk("abort_zwe", int'(z_we_o), 0);
        repeat (20) begin
            @(negedge clk);
            if (z_we_o || done_o) nw++;
            if (err_o) ne++;
        end
        chk("abort_quiet", nw, 0);
        chk("abort_err_once", ne, 0);
    endtask
`endif

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outputs_zero",
            int'({addr_x_o, addr_y_o, addr_z_o, rd_en_o, mac_clr_o, mac_en_o,
                  z_we_o, busy_o, done_o, err_o}), 0);
        rst_i = 1'b0;
        @(negedge clk);

        run_scn(3, 2, 19, 4, 1'b0);
        check_pairs_3x2();

        run_scn(1, 1, 5, 1, 1'b0);
        chk("n1m1_mac_clr", nclr, 1);
        chk("n1m1_mac_en", nen, 1);

        err_scn(0, 2);
        err_scn(2, 33);

        run_scn(3, 2, 19, 4, 1'b1);
        check_pairs_3x2();

        rst_scn();
        run_scn(2, 2, 14, 3, 1'b0);

        run_scn(32, 1, 32 * 4 + 1, 32, 1'b0);

`ifdef CONV_SEQ_ABORT_EN
        abort_scn();
`endif
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
